// File: rtl/ltpi_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ltpi_pkg
// Description : Shared types and constants for the LTPI AVMM initiator model.
//               Holds the initiator state encoding and the AVMM response codes
//               produced by the initiator itself (normal OKAY and the
//               locally generated timeout code).
// Revision    : 1.0 - initial release
//==============================================================================
package ltpi_pkg;

    // Initiator transaction state
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } avmm_init_state_t;

    // Response code reported for locally completed writes
    localparam logic [1:0] AVMM_RSP_OKAY    = 2'b00;
    // Response code reported when the transaction times out
    localparam logic [1:0] AVMM_RSP_TIMEOUT = 2'b11;

endpackage : ltpi_pkg
`default_nettype wire

// File: rtl/ltpi_avmm_initiator_model.sv
`default_nettype none
//==============================================================================
// Module      : ltpi_avmm_initiator_model
// Description : Single-outstanding Avalon-MM initiator. Turns one command
//               handshake into one AVMM read or write and returns the
//               completion (data, response code, timeout flag) on a response
//               handshake. Transactions that do not complete within
//               TIMEOUT_CYCLES are terminated locally with response 2'b11.
//
// Ports       : clk, reset            - clock, async active-high reset
//               cmd_*                 - command handshake (valid/ready)
//               rsp_*                 - completion handshake (valid/ready)
//               avmm_*                - Avalon-MM initiator interface
//               busy                  - transaction in progress
//               txn_count             - completed transactions (wrapping)
//               timeout_count         - timed-out transactions (saturating)
//               stray_rsp             - sticky: unexpected rdvalid/wrvalid
// Revision    : 1.0 - initial release
//==============================================================================
module ltpi_avmm_initiator_model
    import ltpi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int WRITE_RSP_EN   = 1
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_byteen,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,

    output logic [ADDR_WIDTH-1:0]     avmm_addr,
    output logic                      avmm_read,
    output logic                      avmm_write,
    output logic [DATA_WIDTH-1:0]     avmm_wdata,
    output logic [DATA_WIDTH/8-1:0]   avmm_byteen,
    input  logic                      avmm_waitrq,
    input  logic                      avmm_rdvalid,
    input  logic                      avmm_wrvalid,
    input  logic [1:0]                avmm_response,
    input  logic [DATA_WIDTH-1:0]     avmm_rdata,

    output logic                      busy,
    output logic [15:0]               txn_count,
    output logic [7:0]                timeout_count,
    output logic                      stray_rsp
);

    localparam int c_be_width  = DATA_WIDTH / 8;
    localparam int c_cnt_width = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_width-1:0] c_to_limit = c_cnt_width'(TIMEOUT_CYCLES - 1);

    avmm_init_state_t r_state;
    avmm_init_state_t w_state_nxt;

    logic                   r_op;          // 1 = write
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [c_be_width-1:0]  r_byteen;
    logic [c_cnt_width-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]  r_rsp_rdata;
    logic [1:0]             r_rsp_resp;
    logic                   r_rsp_timeout;
    logic [15:0]            r_txn_count;
    logic [7:0]             r_timeout_count;
    logic                   r_stray;

    logic                   w_accept_cmd;
    logic                   w_cmpl;
    logic [DATA_WIDTH-1:0]  w_cmpl_rdata;
    logic [1:0]             w_cmpl_resp;
    logic                   w_timeout;
    logic                   w_stray;
    logic                   w_rsp_hs;
    logic                   w_limit;
    logic                   w_any_rsp;

    assign w_limit   = (r_cnt == c_to_limit);
    assign w_any_rsp = avmm_rdvalid | avmm_wrvalid;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and completion decode
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_accept_cmd = 1'b0;
        w_cmpl       = 1'b0;
        w_cmpl_rdata = '0;
        w_cmpl_resp  = AVMM_RSP_OKAY;
        w_timeout    = 1'b0;
        w_stray      = 1'b0;
        w_rsp_hs     = 1'b0;

        case (r_state)
            IDLE: begin
                w_stray = w_any_rsp;
                if (cmd_valid) begin
                    w_accept_cmd = 1'b1;
                    w_state_nxt  = REQ;
                end
            end

            REQ: begin
                if (avmm_waitrq) begin
                    // Nothing is outstanding at the target before acceptance
                    w_stray = w_any_rsp;
                end else if (!r_op) begin
                    w_cmpl       = avmm_rdvalid;
                    w_cmpl_rdata = avmm_rdata;
                    w_cmpl_resp  = avmm_response;
                    w_stray      = avmm_wrvalid;
                end else if (WRITE_RSP_EN != 0) begin
                    w_cmpl      = avmm_wrvalid;
                    w_cmpl_resp = avmm_response;
                    w_stray     = avmm_rdvalid;
                end else begin
                    // Posted write: acceptance is the completion
                    w_cmpl      = 1'b1;
                    w_cmpl_resp = AVMM_RSP_OKAY;
                    w_stray     = w_any_rsp;
                end

                // A completion in the limit cycle takes priority over timeout
                if (w_cmpl) begin
                    w_state_nxt = DONE;
                end else if (w_limit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end else if (!avmm_waitrq) begin
                    w_state_nxt = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                if (!r_op) begin
                    w_cmpl       = avmm_rdvalid;
                    w_cmpl_rdata = avmm_rdata;
                    w_cmpl_resp  = avmm_response;
                    w_stray      = avmm_wrvalid;
                end else begin
                    w_cmpl      = avmm_wrvalid;
                    w_cmpl_resp = avmm_response;
                    w_stray     = avmm_rdvalid;
                end

                if (w_cmpl) begin
                    w_state_nxt = DONE;
                end else if (w_limit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                w_stray = w_any_rsp;
                if (rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Command capture, timeout counter and completion capture
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_byteen      <= '0;
            r_cnt         <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept_cmd) begin
                r_op     <= cmd_write;
                r_addr   <= cmd_addr;
                r_wdata  <= cmd_wdata;
                r_byteen <= cmd_byteen;
                r_cnt    <= '0;
            end else if ((r_state == REQ) || (r_state == WAIT_RSP)) begin
                r_cnt <= r_cnt + c_cnt_width'(1);
            end

            if (w_cmpl) begin
                r_rsp_rdata   <= w_cmpl_rdata;
                r_rsp_resp    <= w_cmpl_resp;
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= AVMM_RSP_TIMEOUT;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Statistics and sticky stray-response flag
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_txn_count     <= '0;
            r_timeout_count <= '0;
            r_stray         <= 1'b0;
        end else begin
            if (w_rsp_hs) begin
                r_txn_count <= r_txn_count + 16'd1;
                if (r_rsp_timeout && (r_timeout_count != 8'hFF)) begin
                    r_timeout_count <= r_timeout_count + 8'd1;
                end
            end
            if (w_stray) begin
                r_stray <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs. Request strobes decode straight from the state register so an
    // asynchronous reset removes them without waiting for a clock edge;
    // cmd_ready is masked by reset so every output reads 0 while in reset.
    //--------------------------------------------------------------------------
    assign cmd_ready     = (r_state == IDLE) & ~reset;
    assign avmm_read     = (r_state == REQ) & ~r_op;
    assign avmm_write    = (r_state == REQ) &  r_op;
    assign avmm_addr     = r_addr;
    assign avmm_wdata    = r_wdata;
    assign avmm_byteen   = r_byteen;
    assign rsp_valid     = (r_state == DONE);
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;
    assign busy          = (r_state != IDLE);
    assign txn_count     = r_txn_count;
    assign timeout_count = r_timeout_count;
    assign stray_rsp     = r_stray;

endmodule : ltpi_avmm_initiator_model
`default_nettype wire

// File: tb/tb_ltpi_avmm_initiator_model.sv
`default_nettype none
//==============================================================================
// Module      : tb_ltpi_avmm_initiator_model
// Description : Directed self-checking bench for ltpi_avmm_initiator_model
//               (TIMEOUT_CYCLES = 16, WRITE_RSP_EN = 1). A small behavioural
//               AVMM target with programmable wait states, response latency
//               and response code answers the DUT.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ltpi_avmm_initiator_model;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_byteen;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [31:0] avmm_addr, avmm_wdata, avmm_rdata;
    logic        avmm_read, avmm_write, avmm_waitrq;
    logic [3:0]  avmm_byteen;
    logic        avmm_rdvalid = 1'b0;
    logic        avmm_wrvalid = 1'b0;
    logic [1:0]  avmm_response;
    logic        busy, stray_rsp;
    logic [15:0] txn_count;
    logic [7:0]  timeout_count;

    int n_vec = 0;
    int n_err = 0;

    // Target model controls
    int          tgt_wait  = 0;
    int          tgt_lat   = 1;
    logic        tgt_never = 1'b0;
    logic [1:0]  tgt_resp  = 2'b00;

    // Target model state
    logic [31:0] mem [16];
    int          wait_cnt  = 0;
    int          pend_cnt  = 0;
    logic        pend_rd   = 1'b0;
    logic [31:0] pend_data = '0;
    logic [31:0] tgt_rdata = '0;

    always #5 clk = ~clk;

    ltpi_avmm_initiator_model #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16),
        .WRITE_RSP_EN   (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_byteen    (cmd_byteen),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .avmm_addr     (avmm_addr),
        .avmm_read     (avmm_read),
        .avmm_write    (avmm_write),
        .avmm_wdata    (avmm_wdata),
        .avmm_byteen   (avmm_byteen),
        .avmm_waitrq   (avmm_waitrq),
        .avmm_rdvalid  (avmm_rdvalid),
        .avmm_wrvalid  (avmm_wrvalid),
        .avmm_response (avmm_response),
        .avmm_rdata    (avmm_rdata),
        .busy          (busy),
        .txn_count     (txn_count),
        .timeout_count (timeout_count),
        .stray_rsp     (stray_rsp)
    );

    //--------------------------------------------------------------------------
    // Behavioural AVMM target
    //--------------------------------------------------------------------------
    function automatic logic [31:0] merge(input logic [31:0] old_d,
                                          input logic [31:0] new_d,
                                          input logic [3:0]  be);
        logic [31:0] m;
        m = old_d;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[8*b +: 8] = new_d[8*b +: 8];
        end
        return m;
    endfunction

    assign avmm_waitrq   = (avmm_read | avmm_write) & (tgt_never | (wait_cnt < tgt_wait));
    assign avmm_response = tgt_resp;
    assign avmm_rdata    = tgt_rdata;

    always @(posedge clk) begin
        avmm_rdvalid <= 1'b0;
        avmm_wrvalid <= 1'b0;
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[4] <= 32'h1234_5678;
        end
        if (pend_cnt == 1) begin
            avmm_rdvalid <= pend_rd;
            avmm_wrvalid <= ~pend_rd;
            tgt_rdata    <= pend_data;
        end
        if (pend_cnt != 0) pend_cnt <= pend_cnt - 1;
        if (avmm_read | avmm_write) begin
            if (avmm_waitrq) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt <= 0;
                if (avmm_write)
                    mem[avmm_addr[5:2]] <= merge(mem[avmm_addr[5:2]], avmm_wdata, avmm_byteen);
                if (tgt_lat <= 1) begin
                    avmm_rdvalid <= avmm_read;
                    avmm_wrvalid <= avmm_write;
                    tgt_rdata    <= avmm_read ? mem[avmm_addr[5:2]] : 32'h0;
                end else begin
                    pend_cnt  <= tgt_lat - 1;
                    pend_rd   <= avmm_read;
                    pend_data <= avmm_read ? mem[avmm_addr[5:2]] : 32'h0;
                end
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    //--------------------------------------------------------------------------
    // Helpers
    //--------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = a;
        cmd_wdata  = d;
        cmd_byteen = be;
    endtask

    task automatic wait_rsp(input string tag, input int max_cyc);
        int cyc;
        cyc = 0;
        while (!rsp_valid && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        check(tag, {95'd0, rsp_valid}, 96'd1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a,
                           output logic [31:0] d, output logic [1:0] r, output logic t);
        drive_cmd(1'b0, a, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        wait_rsp(tag, 64);
        d = rsp_rdata;
        r = rsp_resp;
        t = rsp_timeout;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    //--------------------------------------------------------------------------
    // Directed sequence
    //--------------------------------------------------------------------------
    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic        rt;

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_byteen = '0;
        rsp_ready  = 1'b0;

        repeat (3) tick();
        check("reset_ctl", {cmd_ready, rsp_valid, rsp_timeout, rsp_resp, avmm_read, avmm_write, busy, stray_rsp},
              {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset_data", {rsp_rdata, avmm_addr, avmm_wdata}, 96'd0);
        check("reset_cnt", {avmm_byteen, txn_count, timeout_count}, 28'd0);
        reset = 1'b0;
        tick();
        check("idle_after_reset", {cmd_ready, busy, rsp_valid}, 3'b100);

        // Read 0x10, zero wait states, rdvalid one cycle after acceptance
        drive_cmd(1'b0, 32'h10, 32'h0, 4'hF);
        check("rd_cmd_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("rd_req_n1", {avmm_read, avmm_write, avmm_addr, avmm_byteen}, {1'b1, 1'b0, 32'h10, 4'hF});
        tick();
        check("rd_n2_quiet", {rsp_valid, avmm_read, cmd_ready}, 3'b000);
        tick();
        check("rd_n3_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h1234_5678});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_txn", {rsp_valid, cmd_ready, txn_count}, {1'b0, 1'b1, 16'd1});

        // Write with 5 wait states; request must hold for 6 cycles
        tgt_wait = 5;
        drive_cmd(1'b1, 32'h14, 32'hDEAD_BEEF, 4'b0011);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("wr_hold_%0d", i), {avmm_write, avmm_read, avmm_addr, avmm_wdata, avmm_byteen},
                  {1'b1, 1'b0, 32'h14, 32'hDEAD_BEEF, 4'b0011});
            tick();
        end
        check("wr_dropped", {avmm_write, rsp_valid, busy}, 3'b001);
        tick();
        check("wr_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h0});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tgt_wait = 0;
        do_read("wr_readback_arrive", 32'h14, rd, rr, rt);
        check("wr_readback", {rd, rr, rt}, {32'h0000_BEEF, 2'b00, 1'b0});
        check("txn_after_wr", txn_count, 16'd3);

        // Target never accepts: timeout at N+17
        tgt_never = 1'b1;
        drive_cmd(1'b0, 32'h20, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        repeat (15) tick();
        check("to_n16_pending", {avmm_read, rsp_valid}, 2'b10);
        tick();
        check("to_n17_rsp", {avmm_read, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
              {1'b0, 1'b1, 1'b1, 2'b11, 32'h0});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tgt_never = 1'b0;
        check("to_counts", {timeout_count, txn_count, stray_rsp}, {8'd1, 16'd4, 1'b0});

        // Completion in the limit cycle (counter = 15) wins over timeout
        tgt_wait = 14;
        drive_cmd(1'b0, 32'h10, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        repeat (15) tick();
        check("lim_n16", {avmm_read, avmm_rdvalid, rsp_valid}, 3'b010);
        tick();
        check("lim_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h1234_5678});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("lim_counts", {timeout_count, txn_count}, {8'd1, 16'd5});

        // Acceptance in the limit cycle without completion: timeout, late rdvalid is stray
        tgt_wait = 15;
        drive_cmd(1'b0, 32'h10, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        repeat (15) tick();
        check("lim1_n16", {avmm_read, avmm_waitrq, rsp_valid}, 3'b100);
        tick();
        check("lim1_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b11, 32'h0});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tgt_wait = 0;
        check("lim1_counts", {stray_rsp, timeout_count, txn_count}, {1'b1, 8'd2, 16'd6});

        // Response held for 10 cycles while a second command waits
        tgt_resp = 2'b10;
        drive_cmd(1'b1, 32'h18, 32'hCAFE_F00D, 4'hF);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        drive_cmd(1'b0, 32'h18, 32'h0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold_%0d", i), {cmd_ready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
                  {1'b0, 1'b1, 1'b0, 2'b10, 32'h0});
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hold_accept", {cmd_ready, rsp_valid, txn_count}, {1'b1, 1'b0, 16'd7});
        tick();
        cmd_valid = 1'b0;
        check("hold_second_req", {avmm_read, avmm_addr}, {1'b1, 32'h18});
        wait_rsp("hold_second_arrive", 64);
        check("hold_second_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, 2'b10, 32'hCAFE_F00D});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tgt_resp = 2'b00;
        check("hold_txn", txn_count, 16'd8);

        // Reset while waiting for a read; the late rdvalid is stray
        tgt_lat = 4;
        drive_cmd(1'b0, 32'h10, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rst_in_wait", {busy, avmm_read, rsp_valid}, 3'b100);
        reset = 1'b1;
        #1;
        check("rst_async", {cmd_ready, busy, avmm_read, avmm_write, rsp_valid, txn_count, timeout_count, stray_rsp},
              {5'b00000, 16'd0, 8'd0, 1'b0});
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("rst_late_stray", {stray_rsp, busy, rsp_valid, txn_count}, {1'b1, 1'b0, 1'b0, 16'd0});
        tgt_lat = 1;
        do_read("rst_next_arrive", 32'h10, rd, rr, rt);
        check("rst_next_rd", {rd, rr, rt}, {32'h1234_5678, 2'b00, 1'b0});
        check("rst_next_cnt", {txn_count, stray_rsp}, {16'd1, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ltpi_avmm_initiator_model
`default_nettype wire

// File: doc/ltpi_avmm_initiator_model.md
Name: ltpi_avmm_initiator_model

Overview:
- Single-outstanding Avalon-MM initiator. It converts a command handshake (read/write, address, data, byte enables) into one AVMM transaction and returns the completion on a response handshake.
- It is the initiator counterpart of avmm_target_model. It drives the AVMM target port of the controller-side mgmt_ltpi_top, so traffic tunnels over LTPI to the target-side AVMM mux.
- It is used in controller-side top levels and benches as the host-side AVMM stimulus and readback engine.

Parameters:
- ADDR_WIDTH, 32, AVMM address width.
- DATA_WIDTH, 32, AVMM data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 1024, maximum cycles from first request assertion to completion; minimum 2.
- WRITE_RSP_EN, 1. When 1, a write completes on writeresponsevalid. When 0, a write completes on acceptance with response 2'b00.

Ports:
- clk  in  1  system clock (60 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transaction address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_byteen  in  DATA_WIDTH/8  byte enables.
- rsp_valid  out  1  completion available.
- rsp_ready  in  1  completion consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_resp  out  2  AVMM response code; 2'b11 on timeout.
- rsp_timeout  out  1  completion was produced by timeout.
- avmm_addr  out  ADDR_WIDTH  AVMM address.
- avmm_read  out  1  AVMM read request.
- avmm_write  out  1  AVMM write request.
- avmm_wdata  out  DATA_WIDTH  AVMM write data.
- avmm_byteen  out  DATA_WIDTH/8  AVMM byte enables.
- avmm_waitrq  in  1  AVMM waitrequest.
- avmm_rdvalid  in  1  AVMM readdatavalid.
- avmm_wrvalid  in  1  AVMM writeresponsevalid.
- avmm_response  in  2  AVMM response code.
- avmm_rdata  in  DATA_WIDTH  AVMM read data.
- busy  out  1  high whenever state is not IDLE.
- txn_count  out  16  completed transactions; wraps 0xFFFF -> 0.
- timeout_count  out  8  timeouts; saturates at 0xFF.
- stray_rsp  out  1  sticky flag, set when rdvalid/wrvalid arrives while no response is expected.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset is asynchronous. Asserting reset mid-transaction drops avmm_read/avmm_write immediately, discards the transaction, and clears the counters.
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register op/addr/wdata/byteen and go to REQ.
  - A command accepted in cycle N has avmm_read or avmm_write high in cycle N+1.
- REQ:
  - avmm_read = !op; avmm_write = op.
  - addr/wdata/byteen are held stable until the first cycle in which avmm_waitrq == 0; that cycle is acceptance.
  - On acceptance with no same-cycle completion, the request is dropped the next cycle and state goes to WAIT_RSP.
  - Write with WRITE_RSP_EN = 0: acceptance completes it; go to DONE.
- WAIT_RSP:
  - A read completes on avmm_rdvalid: capture avmm_rdata and avmm_response.
  - A write completes on avmm_wrvalid: capture avmm_response; rdata = 0.
  - A completion asserted in the acceptance cycle itself is honoured: REQ goes directly to DONE.
- Timeout:
  - A counter clears on entry to REQ and increments every cycle in REQ or WAIT_RSP.
  - If the counter equals TIMEOUT_CYCLES-1 and no completion occurs that cycle, go to DONE with rsp_timeout = 1, rsp_resp = 2'b11, rsp_rdata = 0.
  - On timeout, requests are dropped even if waitrequest is still high.
  - Completion in the limit cycle wins over timeout.
- DONE:
  - rsp_valid = 1, with the rsp_* fields held stable until rsp_ready.
  - On rsp_ready, go to IDLE and increment txn_count; timeout_count also increments if timed out.
  - The next command can be accepted one cycle after the rsp handshake.
- Minimum latency: read with waitrq = 0 at N+1 and rdvalid at N+2 gives rsp_valid at N+3.
- Stray responses: rdvalid/wrvalid in IDLE, REQ (before acceptance) or DONE is ignored and sets stray_rsp. A wrvalid while waiting for a read, or the reverse, is also stray.
- No pipelining: at most one outstanding transaction.

Decomposition:
- ltpi_pkg gets:
  - the state enum avmm_init_state_t;
  - constants AVMM_RSP_OKAY = 2'b00 and AVMM_RSP_TIMEOUT = 2'b11.
- Single module; the timeout counter is inline (no sub-module).

Test Plan:
- Read 0x0000_0010 against avmm_target_model (0 wait states, rdvalid at N+2) -> rsp_valid at N+3, rsp_rdata = model value, rsp_resp = 00, txn_count = 1.
- Write 0xDEAD_BEEF, byteen 4'b0011, to 0x14 with waitrq high for 5 cycles -> avmm_addr/avmm_wdata stable for all 6 request cycles, write dropped after acceptance, response 00 on wrvalid; readback returns 0x0000_BEEF.
- TIMEOUT_CYCLES = 16, target never drops waitrq -> avmm_read drops and rsp_valid rises at N+17 with rsp_timeout = 1, rsp_resp = 11, rsp_rdata = 0; timeout_count = 1.
- Completion exactly at counter = TIMEOUT_CYCLES-1 -> normal completion, rsp_timeout = 0.
- rsp_ready held low for 10 cycles, then a second cmd_valid -> cmd_ready stays 0 and rsp fields are stable; the second command is accepted 1 cycle after the handshake.
- Reset asserted while in WAIT_RSP; a late rdvalid after reset release -> outputs 0 immediately, stray_rsp = 1, and the next read completes normally.
